// File: rtl/kbd_loader_pkg.sv
// rtl/kbd_loader_pkg.sv - key codes, state encoding and accumulator ops for the keyboard program loader
package kbd_loader_pkg;

  localparam int DIGITS = 8;

  localparam logic [5:0] KEY_ENTER  = 6'h10;
  localparam logic [5:0] KEY_BKSP   = 6'h11;
  localparam logic [5:0] KEY_ESC    = 6'h12;
  localparam logic [5:0] KEY_RUN    = 6'h13;
  localparam logic [5:0] KEY_RELOAD = 6'h14;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2,
    RUN   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ACC_HOLD    = 2'd0,
    ACC_SHIFT   = 2'd1,
    ACC_UNSHIFT = 2'd2,
    ACC_CLEAR   = 2'd3
  } acc_op_e;

endpackage

// File: rtl/loader_word_accum.sv
// rtl/loader_word_accum.sv - hex digit accumulator holding the word under construction
module loader_word_accum
  import kbd_loader_pkg::*;
#(
  parameter int MAX_DIGITS = DIGITS
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  acc_op_e     op_i,
  input  logic [3:0]  digit_i,
  output logic [31:0] word_o,
  output logic [3:0]  cnt_o
);

  logic [31:0] word_q, word_d;
  logic [3:0]  cnt_q, cnt_d;

  // Shift and unshift saturate here as well, so a stray op can never corrupt the count.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    case (op_i)
      ACC_SHIFT: begin
        if (cnt_q < 4'(MAX_DIGITS)) begin
          word_d = {word_q[27:0], digit_i};
          cnt_d  = cnt_q + 4'd1;
        end
      end
      ACC_UNSHIFT: begin
        if (cnt_q != 4'd0) begin
          word_d = word_q >> 4;
          cnt_d  = cnt_q - 4'd1;
        end
      end
      ACC_CLEAR: begin
        word_d = 32'd0;
        cnt_d  = 4'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      word_q <= 32'd0;
      cnt_q  <= 4'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o = word_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/kbd_imem_loader.sv
// rtl/kbd_imem_loader.sv - keyboard-driven instruction memory loader with processor reset hold
module kbd_imem_loader
  import kbd_loader_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DIGITS = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [5:0]        key_code,
  input  logic              key_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic [31:0]       word_buf,
  output logic [3:0]        digit_cnt,
  output logic [ADDR_W:0]   word_count,
  output logic              load_done,
  output logic              key_err
);

  state_e            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   word_count_q;
  logic              imem_we_q, cpu_reset_q, load_done_q, key_err_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  acc_op_e           acc_op;

  logic key_is_digit, buf_full, buf_empty;
  assign key_is_digit = (key_code[5:4] == 2'b00);
  assign buf_full     = (digit_cnt >= 4'(DIGITS));
  assign buf_empty    = (digit_cnt == 4'd0);

  loader_word_accum #(.MAX_DIGITS(DIGITS)) u_accum (
    .clk_i   (CLK),
    .rst_ni  (reset),
    .op_i    (acc_op),
    .digit_i (key_code[3:0]),
    .word_o  (word_buf),
    .cnt_o   (digit_cnt)
  );

  always_comb begin
    acc_op = ACC_HOLD;
    case (state_q)
      LOAD: begin
        if (key_valid) begin
          if (key_is_digit && !buf_full)              acc_op = ACC_SHIFT;
          else if (key_code == KEY_BKSP && !buf_empty) acc_op = ACC_UNSHIFT;
          else if (key_code == KEY_ESC)                acc_op = ACC_CLEAR;
        end
      end
      WRITE:   if (imem_we_q) acc_op = ACC_CLEAR;
      FULL:    if (key_valid && key_code == KEY_ESC) acc_op = ACC_CLEAR;
      RUN:     if (key_valid && key_code == KEY_RELOAD) acc_op = ACC_CLEAR;
      default: acc_op = ACC_HOLD;
    endcase
  end

  // WRITE spans two cycles: imem_we_q low marks the port-setup cycle, high marks the commit cycle.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q      <= LOAD;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      key_err_q    <= 1'b0;
    end else begin
      key_err_q <= 1'b0;
      imem_we_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (key_valid) begin
            if (key_is_digit) begin
              if (buf_full) key_err_q <= 1'b1;
            end else begin
              case (key_code)
                KEY_ENTER: if (buf_empty) key_err_q <= 1'b1; else state_q <= WRITE;
                KEY_BKSP:  if (buf_empty) key_err_q <= 1'b1;
                KEY_ESC:   ;
                KEY_RUN: begin
                  if (buf_empty) begin
                    state_q     <= RUN;
                    cpu_reset_q <= 1'b0;
                    load_done_q <= 1'b1;
                  end else begin
                    key_err_q <= 1'b1;
                  end
                end
                default:   key_err_q <= 1'b1;
              endcase
            end
          end
        end
        WRITE: begin
          if (key_valid) key_err_q <= 1'b1;
          if (!imem_we_q) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= wr_ptr_q;
            imem_wdata_q <= word_buf;
          end else begin
            word_count_q <= word_count_q + 1'b1;
            if (wr_ptr_q == {ADDR_W{1'b1}}) begin
              state_q <= FULL;
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
              state_q  <= LOAD;
            end
          end
        end
        FULL: begin
          if (key_valid) begin
            if (key_code == KEY_RUN) begin
              state_q     <= RUN;
              cpu_reset_q <= 1'b0;
              load_done_q <= 1'b1;
            end else if (key_code != KEY_ESC) begin
              key_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (key_valid && key_code == KEY_RELOAD) begin
            state_q      <= LOAD;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign word_count = word_count_q;
  assign load_done  = load_done_q;
  assign key_err    = key_err_q;

endmodule

// File: tb/tb_kbd_imem_loader.sv
// tb/tb_kbd_imem_loader.sv - directed self-checking bench for kbd_imem_loader
module tb_kbd_imem_loader;
  import kbd_loader_pkg::*;

  localparam int AW = 2;

  logic          CLK = 1'b0;
  logic          reset = 1'b0;
  logic [5:0]    key_code = 6'd0;
  logic          key_valid = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic [31:0]   word_buf;
  logic [3:0]    digit_cnt;
  logic [AW:0]   word_count;
  logic          load_done;
  logic          key_err;

  int checks = 0;
  int errors = 0;

  kbd_imem_loader #(.ADDR_W(AW), .DIGITS(8)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .word_buf   (word_buf),
    .digit_cnt  (digit_cnt),
    .word_count (word_count),
    .load_done  (load_done),
    .key_err    (key_err)
  );

  always #5 CLK = ~CLK;

  // Returns on the falling edge after the sampling edge, so outputs already reflect the key.
  task automatic press(input logic [5:0] code);
    @(negedge CLK);
    key_code  = code;
    key_valid = 1'b1;
    @(negedge CLK);
    key_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    checks++; if (word_buf !== 32'd0) begin errors++; $display("FAIL reset_word_buf got %h exp 0", word_buf); end
    checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL reset_digit_cnt got %0d exp 0", digit_cnt); end
    checks++; if (word_count !== 3'd0) begin errors++; $display("FAIL reset_word_count got %0d exp 0", word_count); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_imem_we got %b exp 0", imem_we); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset got %b exp 1", cpu_reset); end
    checks++; if (load_done !== 1'b0 || key_err !== 1'b0) begin errors++; $display("FAIL reset_done_err got %b%b exp 00", load_done, key_err); end
    checks++; if (imem_addr !== 2'd0 || imem_wdata !== 32'd0) begin errors++; $display("FAIL reset_port got %h/%h exp 0/0", imem_addr, imem_wdata); end
  endtask

  task automatic test_full_word;
    for (int d = 1; d <= 8; d++) press(6'(d));
    checks++; if (word_buf !== 32'h12345678) begin errors++; $display("FAIL fw_word_buf got %h exp 12345678", word_buf); end
    checks++; if (digit_cnt !== 4'd8) begin errors++; $display("FAIL fw_digit_cnt got %0d exp 8", digit_cnt); end
    press(KEY_ENTER);
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL fw_we_early got %b exp 0", imem_we); end
    @(negedge CLK);
    checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL fw_we got %b exp 1", imem_we); end
    checks++; if (imem_addr !== 2'd0 || imem_wdata !== 32'h12345678) begin errors++; $display("FAIL fw_port got %h/%h exp 0/12345678", imem_addr, imem_wdata); end
    checks++; if (word_count !== 3'd0) begin errors++; $display("FAIL fw_count_early got %0d exp 0", word_count); end
    @(negedge CLK);
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL fw_we_end got %b exp 0", imem_we); end
    checks++; if (word_count !== 3'd1 || digit_cnt !== 4'd0) begin errors++; $display("FAIL fw_after got cnt %0d dig %0d exp 1 0", word_count, digit_cnt); end
  endtask

  task automatic test_backspace;
    press(6'hA); press(6'hB); press(KEY_BKSP);
    checks++; if (word_buf !== 32'hA || digit_cnt !== 4'd1) begin errors++; $display("FAIL bk_unshift got %h/%0d exp a/1", word_buf, digit_cnt); end
    press(6'hC);
    press(KEY_ENTER);
    @(negedge CLK);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd1 || imem_wdata !== 32'h000000AC) begin errors++; $display("FAIL bk_write got %b %h %h exp 1 1 000000ac", imem_we, imem_addr, imem_wdata); end
    @(negedge CLK);
    checks++; if (word_count !== 3'd2) begin errors++; $display("FAIL bk_count got %0d exp 2", word_count); end
    press(KEY_ENTER);
    checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL empty_enter_err got %b exp 1", key_err); end
    @(negedge CLK);
    checks++; if (key_err !== 1'b0 || imem_we !== 1'b0) begin errors++; $display("FAIL empty_enter_after got err %b we %b exp 0 0", key_err, imem_we); end
    @(negedge CLK);
    checks++; if (imem_we !== 1'b0 || word_count !== 3'd2) begin errors++; $display("FAIL empty_enter_nowrite got we %b cnt %0d exp 0 2", imem_we, word_count); end
    press(KEY_BKSP);
    checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL empty_bksp_err got %b exp 1", key_err); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 8; i++) press(6'hF);
    checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL ov_8th_err got %b exp 0", key_err); end
    press(6'hF);
    checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL ov_9th_err got %b exp 1", key_err); end
    checks++; if (word_buf !== 32'hFFFFFFFF || digit_cnt !== 4'd8) begin errors++; $display("FAIL ov_buf got %h/%0d exp ffffffff/8", word_buf, digit_cnt); end
    press(KEY_ESC);
    checks++; if (word_buf !== 32'd0 || digit_cnt !== 4'd0 || key_err !== 1'b0) begin errors++; $display("FAIL ov_esc got %h/%0d err %b exp 0/0 0", word_buf, digit_cnt, key_err); end
    press(6'h15);
    checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL invalid_key_err got %b exp 1", key_err); end
  endtask

  task automatic test_run_partial;
    press(6'h1); press(6'h2); press(6'h3);
    press(KEY_RUN);
    checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL runp_err got %b exp 1", key_err); end
    checks++; if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL runp_hold got %b%b exp 10", cpu_reset, load_done); end
    checks++; if (word_buf !== 32'h123 || digit_cnt !== 4'd3) begin errors++; $display("FAIL runp_buf got %h/%0d exp 123/3", word_buf, digit_cnt); end
  endtask

  task automatic test_write_drop;
    press(KEY_ENTER);
    key_code  = 6'h5;
    key_valid = 1'b1;
    @(negedge CLK);
    key_valid = 1'b0;
    checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL wd_err got %b exp 1", key_err); end
    checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd2 || imem_wdata !== 32'h123) begin errors++; $display("FAIL wd_write got %b %h %h exp 1 2 123", imem_we, imem_addr, imem_wdata); end
    @(negedge CLK);
    checks++; if (word_count !== 3'd3 || word_buf !== 32'd0 || digit_cnt !== 4'd0) begin errors++; $display("FAIL wd_after got %0d %h %0d exp 3 0 0", word_count, word_buf, digit_cnt); end
  endtask

  task automatic test_full_run_reload;
    press(6'hD);
    press(KEY_ENTER);
    @(negedge CLK);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd3 || imem_wdata !== 32'hD) begin errors++; $display("FAIL full_last got %b %h %h exp 1 3 d", imem_we, imem_addr, imem_wdata); end
    @(negedge CLK);
    checks++; if (word_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", word_count); end
    press(6'h7);
    checks++; if (key_err !== 1'b1 || digit_cnt !== 4'd0) begin errors++; $display("FAIL full_digit got err %b dig %0d exp 1 0", key_err, digit_cnt); end
    press(KEY_ENTER);
    @(negedge CLK);
    checks++; if (imem_we !== 1'b0 || word_count !== 3'd4) begin errors++; $display("FAIL full_nowrite got we %b cnt %0d exp 0 4", imem_we, word_count); end
    press(KEY_RUN);
    checks++; if (cpu_reset !== 1'b0 || load_done !== 1'b1 || key_err !== 1'b0) begin errors++; $display("FAIL run got cr %b ld %b err %b exp 0 1 0", cpu_reset, load_done, key_err); end
    press(6'h4);
    checks++; if (key_err !== 1'b0 || digit_cnt !== 4'd0 || cpu_reset !== 1'b0) begin errors++; $display("FAIL run_ignore got err %b dig %0d cr %b exp 0 0 0", key_err, digit_cnt, cpu_reset); end
    press(KEY_RELOAD);
    checks++; if (cpu_reset !== 1'b1 || load_done !== 1'b0 || word_count !== 3'd0) begin errors++; $display("FAIL reload got cr %b ld %b cnt %0d exp 1 0 0", cpu_reset, load_done, word_count); end
    press(6'h9);
    press(KEY_ENTER);
    @(negedge CLK);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd0 || imem_wdata !== 32'h9) begin errors++; $display("FAIL reload_write got %b %h %h exp 1 0 9", imem_we, imem_addr, imem_wdata); end
    @(negedge CLK);
    checks++; if (word_count !== 3'd1) begin errors++; $display("FAIL reload_count got %0d exp 1", word_count); end
  endtask

  task automatic test_reset_in_write;
    press(6'h4);
    press(KEY_ENTER);
    @(negedge CLK);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd1) begin errors++; $display("FAIL rw_we got %b %h exp 1 1", imem_we, imem_addr); end
    reset = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL rw_abort got %b exp 0", imem_we); end
    checks++; if (word_count !== 3'd0 || word_buf !== 32'd0 || digit_cnt !== 4'd0) begin errors++; $display("FAIL rw_state got %0d %h %0d exp 0 0 0", word_count, word_buf, digit_cnt); end
    checks++; if (cpu_reset !== 1'b1 || imem_addr !== 2'd0 || imem_wdata !== 32'd0) begin errors++; $display("FAIL rw_outs got cr %b %h %h exp 1 0 0", cpu_reset, imem_addr, imem_wdata); end
    @(negedge CLK);
    checks++; if (imem_we !== 1'b0 || word_count !== 3'd0) begin errors++; $display("FAIL rw_settle got we %b cnt %0d exp 0 0", imem_we, word_count); end
    press(KEY_RUN);
    checks++; if (cpu_reset !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL empty_run got %b%b exp 01", cpu_reset, load_done); end
  endtask

  initial begin
    test_reset;
    test_full_word;
    test_backspace;
    test_overflow;
    test_run_partial;
    test_write_drop;
    test_full_run_reload;
    test_reset_in_write;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
